// File: rtl/tft43_fill_ctrl.sv
// tft43_fill_ctrl: command master for the TFT43 command sequencer.
// After reset it sends the LCD power-up pair (trigger 1, trigger 2), then
// serves rectangle fills as CASET, RASET, GRAM write and one write-data
// command per pixel. Every command is held until tft_done and is followed
// by exactly one cycle with tft_en low so the sequencer can rearm.
// Optional build macro TFT43_FILL_CLEAR_ON_INIT_EN: a full-screen fill with
// DEFAULT_COLOR runs after register init and before init_done rises.
module tft43_fill_ctrl #(
    parameter int          H_RES         = 800,
    parameter int          V_RES         = 480,
    parameter logic [15:0] DEFAULT_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  logic [15:0] req_color,
    output logic        init_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        tft_en,
    output logic [3:0]  tft_trigger,
    output logic [15:0] tft_data1,
    output logic [15:0] tft_data2,
    input  logic        tft_done
);

    typedef enum logic [3:0] {
        S_LCD_RST, S_INIT, S_IDLE, S_CASET, S_RASET,
        S_GRAM, S_PIX, S_GAP, S_FIN
    } state_t;

    localparam logic [15:0] X_MAX = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

    state_t      state;
    state_t      gap_next;
    logic [15:0] x0, y0, x1, y1, color;
    logic [9:0]  xcnt, ycnt, x_last, y_last;
    logic        clear_mode;
    logic        req_bad;
    logic        cmd_ack;

    // A request is illegal when the rectangle is inverted or leaves the panel.
    assign req_bad = (req_x0 > req_x1) || (req_y0 > req_y1) ||
                     (req_x1 > X_MAX) || (req_y1 > Y_MAX);

    // The sequencer's done only counts while a command is being driven.
    assign cmd_ack = tft_en && tft_done;

    // Single registered FSM: command issue, handshake, gap cycle and pixel counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LCD_RST;
            gap_next    <= S_LCD_RST;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            tft_en      <= 1'b0;
            tft_trigger <= 4'd0;
            tft_data1   <= 16'd0;
            tft_data2   <= 16'd0;
            x0          <= 16'd0;
            y0          <= 16'd0;
            x1          <= 16'd0;
            y1          <= 16'd0;
            color       <= DEFAULT_COLOR;
            xcnt        <= 10'd0;
            ycnt        <= 10'd0;
            x_last      <= 10'd0;
            y_last      <= 10'd0;
            clear_mode  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_LCD_RST: begin
                    if (!tft_en) begin
                        tft_en      <= 1'b1;
                        tft_trigger <= 4'd1;
                        tft_data1   <= 16'd0;
                        tft_data2   <= 16'd0;
                    end else if (tft_done) begin
                        tft_en      <= 1'b0;
                        tft_trigger <= 4'd0;
                        gap_next    <= S_INIT;
                        state       <= S_GAP;
                    end
                end
                S_INIT: begin
                    if (cmd_ack) begin
                        tft_en      <= 1'b0;
                        tft_trigger <= 4'd0;
                        state       <= S_GAP;
`ifdef TFT43_FILL_CLEAR_ON_INIT_EN
                        x0          <= 16'd0;
                        y0          <= 16'd0;
                        x1          <= X_MAX;
                        y1          <= Y_MAX;
                        color       <= DEFAULT_COLOR;
                        x_last      <= 10'(H_RES - 1);
                        y_last      <= 10'(V_RES - 1);
                        xcnt        <= 10'd0;
                        ycnt        <= 10'd0;
                        clear_mode  <= 1'b1;
                        gap_next    <= S_CASET;
`else
                        gap_next    <= S_IDLE;
`endif
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            x0          <= req_x0;
                            y0          <= req_y0;
                            x1          <= req_x1;
                            y1          <= req_y1;
                            color       <= req_color;
                            x_last      <= 10'(req_x1 - req_x0);
                            y_last      <= 10'(req_y1 - req_y0);
                            xcnt        <= 10'd0;
                            ycnt        <= 10'd0;
                            req_ready   <= 1'b0;
                            busy        <= 1'b1;
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd3;
                            tft_data1   <= req_x0;
                            tft_data2   <= req_x1;
                            state       <= S_CASET;
                        end
                    end
                end
                S_CASET, S_RASET, S_GRAM: begin
                    if (cmd_ack) begin
                        tft_en      <= 1'b0;
                        tft_trigger <= 4'd0;
                        state       <= S_GAP;
                        if (state == S_CASET)
                            gap_next <= S_RASET;
                        else if (state == S_RASET)
                            gap_next <= S_GRAM;
                        else
                            gap_next <= S_PIX;
                    end
                end
                S_PIX: begin
                    if (cmd_ack) begin
                        tft_en      <= 1'b0;
                        tft_trigger <= 4'd0;
                        state       <= S_GAP;
                        gap_next    <= S_PIX;
                        if (xcnt == x_last) begin
                            xcnt <= 10'd0;
                            if (ycnt == y_last) begin
                                ycnt     <= 10'd0;
                                gap_next <= clear_mode ? S_IDLE : S_FIN;
                            end else begin
                                ycnt <= ycnt + 10'd1;
                            end
                        end else begin
                            xcnt <= xcnt + 10'd1;
                        end
                    end
                end
                S_GAP: begin
                    state <= gap_next;
                    case (gap_next)
                        S_INIT: begin
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd2;
                            tft_data1   <= 16'd0;
                            tft_data2   <= 16'd0;
                        end
                        S_CASET: begin
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd3;
                            tft_data1   <= x0;
                            tft_data2   <= x1;
                        end
                        S_RASET: begin
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd4;
                            tft_data1   <= y0;
                            tft_data2   <= y1;
                        end
                        S_GRAM: begin
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd5;
                            tft_data1   <= 16'd1;
                            tft_data2   <= 16'd0;
                        end
                        S_PIX: begin
                            tft_en      <= 1'b1;
                            tft_trigger <= 4'd7;
                            tft_data1   <= color;
                            tft_data2   <= 16'd0;
                        end
                        S_FIN: begin
                            done <= 1'b1;
                        end
                        S_IDLE: begin
                            init_done  <= 1'b1;
                            busy       <= 1'b0;
                            req_ready  <= 1'b1;
                            clear_mode <= 1'b0;
                        end
                        default: state <= S_LCD_RST;
                    endcase
                end
                S_FIN: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_LCD_RST;
            endcase
        end
    end

endmodule

// File: doc/tft43_fill_ctrl.md
Name: tft43_fill_ctrl

Overview:
- Command master directly upstream of the TFT43 command sequencer.
- After reset it drives the LCD power-up sequence: trigger 1 (reset), then trigger 2 (register init).
- It then accepts rectangle-fill requests. Each fill is issued as trigger 3 (CASET), trigger 4 (RASET), trigger 5 (GRAM write) and one trigger 7 (write data) per pixel.
- It exposes a valid/ready request port to the pixel/graphics logic above it.

Parameters:
- H_RES, 800, horizontal pixel count; legal x range is 0..H_RES-1.
- V_RES, 480, vertical pixel count; legal y range is 0..V_RES-1.
- DEFAULT_COLOR, 16'h0000, RGB565 value used by the optional clear-on-init fill.

Ports:
- clk  input  1  system clock (10 MHz nominal)
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  fill request present
- req_ready  output  1  controller can accept a request
- req_x0  input  16  rectangle x start
- req_y0  input  16  rectangle y start
- req_x1  input  16  rectangle x end, inclusive
- req_y1  input  16  rectangle y end, inclusive
- req_color  input  16  RGB565 fill colour
- init_done  output  1  high once the LCD power-up sequence has completed
- busy  output  1  a command sequence is in progress
- done  output  1  one-cycle pulse when a fill completes
- err  output  1  one-cycle pulse when a request is rejected
- tft_en  output  1  enable to the sequencer
- tft_trigger  output  4  command code to the sequencer
- tft_data1  output  16  iData1 to the sequencer
- tft_data2  output  16  iData2 to the sequencer
- tft_done  input  1  one-cycle done pulse from the sequencer

Behaviour:
- Reset values: req_ready=0, init_done=0, busy=1, done=0, err=0, tft_en=0, tft_trigger=0, tft_data1=0, tft_data2=0. The FSM enters S_LCD_RST.
- Command handshake:
  - Drive tft_trigger/tft_data1/tft_data2 with tft_en=1 and hold them until tft_done is sampled high.
  - On that same edge: drop tft_en to 0, set tft_trigger to 0, and enter S_GAP.
  - S_GAP lasts exactly one cycle with tft_en=0 (this lets the sequencer clear its step counter), then the FSM moves to the next command state.
  - Minimum cost per command is therefore the sequencer latency plus 1 cycle.
- FSM states:
  - S_LCD_RST: trigger 1.
  - S_INIT: trigger 2.
  - S_IDLE: init_done=1, busy=0, req_ready=1.
  - S_CASET: trigger 3, data1=x0, data2=x1.
  - S_RASET: trigger 4, data1=y0, data2=y1.
  - S_GRAM: trigger 5, data1=1 (write).
  - S_PIX: trigger 7, data1=colour.
  - S_GAP: one cycle, tft_en=0, as above.
  - S_FIN: one cycle with done=1, then S_IDLE.
- Request acceptance (S_IDLE):
  - On req_valid && req_ready, latch x0, y0, x1, y1 and colour; req_ready drops on the next cycle.
  - Reject if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES. A rejected request pulses err for one cycle and the FSM stays in S_IDLE; nothing is sent to the sequencer.
- Pixel counting:
  - Nested counters: xcnt counts 0..(x1-x0), ycnt counts 0..(y1-y0); both are 10 bits, sized for 800.
  - After each trigger-7 done: xcnt increments. When xcnt wraps from the last column, it clears and ycnt increments.
  - When the final pixel completes (xcnt and ycnt both at their maximum), go to S_FIN.
  - Pixels per fill = (x1-x0+1)*(y1-y0+1). No multiplier is used.
- Requests arriving while busy are neither accepted nor queued; req_ready stays low.
- done and err are never high in the same cycle.
- Asynchronous reset mid-operation: all outputs return to reset values immediately; the sequence restarts at S_LCD_RST. The latched request is discarded.
- A tft_done sampled in any state where tft_en=0 is ignored.

Optional Feature:
- Macro: TFT43_FILL_CLEAR_ON_INIT_EN.
- When defined: after S_INIT, the controller internally performs a full-screen fill (0,0)-(H_RES-1,V_RES-1) with DEFAULT_COLOR. No done pulse is issued for this fill. init_done and req_ready assert only after its last pixel.
- When undefined: S_INIT is followed directly by S_IDLE.

Test Plan:
- Reset release with a sequencer model answering tft_done after 3 cycles -> trigger 1 then trigger 2 issued, each followed by one tft_en=0 cycle; init_done=1 and req_ready=1 afterwards.
- Request (10,20)-(12,21), colour 16'hF800 -> CASET data1=10 data2=12, RASET data1=20 data2=21, GRAM data1=1, exactly 6 trigger-7 commands with data1=16'hF800, then a single done pulse.
- Single pixel (799,479)-(799,479) -> accepted, exactly 1 trigger-7 command, done pulses; request (0,0)-(800,0) -> err pulse, no tft_en activity.
- req_valid held high during a fill with different coordinates -> ignored; after done, req_ready=1 and the new request is accepted.
- rst_n asserted during pixel 3 of 6 -> tft_en=0 and busy=1 immediately; after release, trigger 1 is reissued.
- With TFT43_FILL_CLEAR_ON_INIT_EN and H_RES=4, V_RES=2 -> 8 trigger-7 commands with DEFAULT_COLOR before init_done rises; no done pulse.
